// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI decode types: Thumb long-branch classification and sequencer states.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    BL_NONE,
    BL_PREFIX,
    BL_SUFFIX,
    BLX_SUFFIX
  } bl_kind_t;

  typedef enum logic {
    BL_ST_IDLE,
    BL_ST_HELD
  } bl_state_t;

  localparam logic [4:0] THUMB_BL_PREFIX_OP  = 5'b11110;
  localparam logic [4:0] THUMB_BL_SUFFIX_OP  = 5'b11111;
  localparam logic [4:0] THUMB_BLX_SUFFIX_OP = 5'b11101;

endpackage

// File: rtl/thumb_bl_classify.sv
// Combinational classifier for Thumb BL/BLX halfwords; also extracts the
// sign-extended high offset and the zero-extended low offset.
module thumb_bl_classify
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          SUPPORT_BLX = 1'b0
) (
  input  logic [15:0]       instr,
  output bl_kind_t          kind,
  output logic [ADDR_W-1:0] hi_off,
  output logic [ADDR_W-1:0] lo_off
);

  always_comb begin
    kind = BL_NONE;
    if (instr[15:11] == THUMB_BL_PREFIX_OP) begin
      kind = BL_PREFIX;
    end else if (instr[15:11] == THUMB_BL_SUFFIX_OP) begin
      kind = BL_SUFFIX;
    end else if (SUPPORT_BLX && (instr[15:11] == THUMB_BLX_SUFFIX_OP)) begin
      kind = BLX_SUFFIX;
    end
  end

  assign hi_off = {{(ADDR_W-23){instr[10]}}, instr[10:0], 12'b0};
  assign lo_off = {{(ADDR_W-12){1'b0}}, instr[10:0], 1'b0};

endmodule

// File: rtl/thumb_bl_sequencer.sv
// Thumb long-branch sequencer: tracks a BL prefix and issues registered branch,
// LR-write and undefined-instruction requests when the matching suffix executes.
module thumb_bl_sequencer
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned ADDR_W           = 32,
  parameter bit          SUPPORT_BLX      = 1'b0,
  parameter bit          PREFIX_WRITES_LR = 1'b1,
  parameter bit          ALLOW_ORPHAN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [15:0]       instr,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [ADDR_W-1:0] lr_rdata,
  output logic              pending,
  output logic              branch_req,
  output logic [ADDR_W-1:0] branch_target,
  output logic              branch_thumb,
  output logic              lr_we,
  output logic [ADDR_W-1:0] lr_wdata,
  output logic              undef_pulse
);

  bl_state_t         state_q, state_d;
  bl_kind_t          kind;
  logic [ADDR_W-1:0] hi_off, lo_off;
  logic [ADDR_W-1:0] part_q, part_d;
  logic              accept;
  logic              br_d, lr_we_d, undef_d, thumb_d;
  logic [ADDR_W-1:0] target_d, lr_wdata_d, base, sum;

  thumb_bl_classify #(
    .ADDR_W      (ADDR_W),
    .SUPPORT_BLX (SUPPORT_BLX)
  ) u_classify (
    .instr  (instr),
    .kind   (kind),
    .hi_off (hi_off),
    .lo_off (lo_off)
  );

  assign accept = instr_valid & ~stall & ~flush;
  assign base   = (state_q == BL_ST_HELD) ? part_q : lr_rdata;
  assign sum    = base + lo_off;

  always_comb begin
    state_d    = state_q;
    part_d     = part_q;
    br_d       = 1'b0;
    lr_we_d    = 1'b0;
    undef_d    = 1'b0;
    target_d   = branch_target;
    thumb_d    = branch_thumb;
    lr_wdata_d = lr_wdata;
    if (flush) begin
      state_d = BL_ST_IDLE;
    end else if (accept) begin
      case (kind)
        BL_PREFIX: begin
          part_d  = instr_pc + ADDR_W'(4) + hi_off;
          state_d = BL_ST_HELD;
          if (PREFIX_WRITES_LR) begin
            lr_we_d    = 1'b1;
            lr_wdata_d = part_d;
          end
        end
        BL_SUFFIX, BLX_SUFFIX: begin
          state_d = BL_ST_IDLE;
          // Orphan without fallback, or BLX with odd offset, is undefined.
          if (((state_q == BL_ST_IDLE) && !ALLOW_ORPHAN) ||
              ((kind == BLX_SUFFIX) && instr[0])) begin
            undef_d = 1'b1;
          end else begin
            br_d       = 1'b1;
            target_d   = (kind == BLX_SUFFIX) ? (sum & {{(ADDR_W-2){1'b1}}, 2'b00}) : sum;
            thumb_d    = (kind != BLX_SUFFIX);
            lr_we_d    = 1'b1;
            lr_wdata_d = (instr_pc + ADDR_W'(2)) | ADDR_W'(1);
          end
        end
        default: state_d = BL_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BL_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q        <= '0;
      branch_req    <= 1'b0;
      branch_target <= '0;
      branch_thumb  <= 1'b1;
      lr_we         <= 1'b0;
      lr_wdata      <= '0;
      undef_pulse   <= 1'b0;
    end else begin
      part_q        <= part_d;
      branch_req    <= br_d;
      branch_target <= target_d;
      branch_thumb  <= thumb_d;
      lr_we         <= lr_we_d;
      lr_wdata      <= lr_wdata_d;
      undef_pulse   <= undef_d;
    end
  end

  assign pending = (state_q == BL_ST_HELD);

endmodule

// File: tb/tb_thumb_bl_sequencer.sv
// Self-checking bench for thumb_bl_sequencer: two configurations driven in
// parallel and compared every cycle against a transaction-level reference model.
module tb_thumb_bl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [15:0] instr = '0;
  logic [31:0] instr_pc = '0, lr_rdata = '0;

  logic        pend0, br0, th0, lwe0, ud0;
  logic [31:0] tgt0, lwd0;
  logic        pend1, br1, th1, lwe1, ud1;
  logic [31:0] tgt1, lwd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  thumb_bl_sequencer #(
    .ADDR_W(32), .SUPPORT_BLX(1'b1), .PREFIX_WRITES_LR(1'b1), .ALLOW_ORPHAN(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .instr(instr), .instr_pc(instr_pc), .lr_rdata(lr_rdata),
    .pending(pend0), .branch_req(br0), .branch_target(tgt0), .branch_thumb(th0),
    .lr_we(lwe0), .lr_wdata(lwd0), .undef_pulse(ud0)
  );

  thumb_bl_sequencer #(
    .ADDR_W(32), .SUPPORT_BLX(1'b0), .PREFIX_WRITES_LR(1'b0), .ALLOW_ORPHAN(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .instr(instr), .instr_pc(instr_pc), .lr_rdata(lr_rdata),
    .pending(pend1), .branch_req(br1), .branch_target(tgt1), .branch_thumb(th1),
    .lr_we(lwe1), .lr_wdata(lwd1), .undef_pulse(ud1)
  );

  // Reference model: per configuration, a "prefix seen" flag plus its partial address.
  bit          c_blx[2]  = '{1'b1, 1'b0};
  bit          c_pwl[2]  = '{1'b1, 1'b0};
  bit          c_orph[2] = '{1'b1, 1'b0};
  bit          m_pend[2];
  logic [31:0] m_part[2];
  bit          e_br[2], e_lwe[2], e_ud[2], e_th[2];
  logic [31:0] e_tgt[2], e_lwd[2];

  function automatic logic [68:0] obs(int k);
    return (k == 0) ? {pend0, br0, tgt0, th0, lwe0, lwd0, ud0}
                    : {pend1, br1, tgt1, th1, lwe1, lwd1, ud1};
  endfunction

  function automatic logic [68:0] expv(int k);
    return {m_pend[k], e_br[k], e_tgt[k], e_th[k], e_lwe[k], e_lwd[k], e_ud[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_part[k] = '0;
      e_br[k] = 0; e_lwe[k] = 0; e_ud[k] = 0; e_th[k] = 1;
      e_tgt[k] = '0; e_lwd[k] = '0;
    end
  endtask

  task automatic model_next();
    for (int k = 0; k < 2; k++) begin
      int          sv;
      logic [31:0] base, t;
      logic [10:0] off;
      bit          is_pre, is_suf, is_blx;
      e_br[k] = 0; e_lwe[k] = 0; e_ud[k] = 0;
      off    = instr[10:0];
      is_pre = (instr[15:11] == 5'd30);
      is_suf = (instr[15:11] == 5'd31);
      is_blx = c_blx[k] && (instr[15:11] == 5'd29);
      if (flush) begin
        m_pend[k] = 0;
      end else if (instr_valid && !stall) begin
        if (is_pre) begin
          sv = (off >= 11'd1024) ? int'(off) - 2048 : int'(off);
          m_part[k] = instr_pc + 32'd4 + 32'(sv * 4096);
          m_pend[k] = 1;
          if (c_pwl[k]) begin e_lwe[k] = 1; e_lwd[k] = m_part[k]; end
        end else if (is_suf || is_blx) begin
          base = m_pend[k] ? m_part[k] : lr_rdata;
          if ((!m_pend[k] && !c_orph[k]) || (is_blx && instr[0])) begin
            e_ud[k] = 1;
          end else begin
            t = base + 32'(int'(off) * 2);
            if (is_blx) t = t - (t % 32'd4);
            e_br[k] = 1; e_tgt[k] = t; e_th[k] = !is_blx;
            e_lwe[k] = 1; e_lwd[k] = (instr_pc + 32'd2) | 32'd1;
          end
          m_pend[k] = 0;
        end else begin
          m_pend[k] = 0;
        end
      end
    end
  endtask

  task automatic drive(bit v, bit s, bit f, logic [15:0] i, logic [31:0] pc, logic [31:0] lr);
    instr_valid = v; stall = s; flush = f; instr = i; instr_pc = pc; lr_rdata = lr;
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1, 0, 0, 16'hF000, 32'h0, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL reset u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({pend0, br0, tgt0, th0, lwe0, lwd0, ud0} !== {2'b00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL reset_values: got %h", {pend0, br0, tgt0, th0, lwe0, lwd0, ud0});
    end
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 16'h0, 32'h0, 32'h0);
  endtask

  task automatic test_bl_basic();
    drive(1, 0, 0, 16'hF000, 32'h0, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL bl_prefix u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({pend0, lwe0, lwd0} !== {2'b11, 32'h4}) begin fails++; $display("FAIL bl_prefix_lr: got %h exp %h", {pend0, lwe0, lwd0}, {2'b11, 32'h4}); end
    drive(1, 0, 0, 16'hF801, 32'h2, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL bl_suffix u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({br0, tgt0, th0, lwe0, lwd0, pend0} !== {1'b1, 32'h6, 2'b11, 32'h5, 1'b0}) begin
      fails++; $display("FAIL bl_branch: got %h exp %h", {br0, tgt0, th0, lwe0, lwd0, pend0}, {1'b1, 32'h6, 2'b11, 32'h5, 1'b0});
    end
    drive(0, 0, 0, 16'h0, 32'h0, 32'h0); step();
    tests++;
    if ({br0, lwe0, tgt0, lwd0} !== {2'b00, 32'h6, 32'h5}) begin
      fails++; $display("FAIL bl_hold: got %h exp %h", {br0, lwe0, tgt0, lwd0}, {2'b00, 32'h6, 32'h5});
    end
  endtask

  task automatic test_neg_wrap();
    drive(1, 0, 0, 16'hF7FF, 32'h1000, 32'h0); step();
    tests++;
    if (lwd0 !== 32'h4) begin fails++; $display("FAIL neg_partial: got %h exp %h", lwd0, 32'h4); end
    drive(1, 0, 0, 16'hFFFE, 32'h1002, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL neg_suffix u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({br0, tgt0, lwd0} !== {1'b1, 32'h1000, 32'h1005}) begin
      fails++; $display("FAIL neg_branch: got %h exp %h", {br0, tgt0, lwd0}, {1'b1, 32'h1000, 32'h1005});
    end
  endtask

  task automatic test_blx();
    drive(1, 0, 0, 16'hF000, 32'h100, 32'h0); step();
    drive(1, 0, 0, 16'hE802, 32'h102, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL blx_suffix u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({br0, tgt0, th0, lwd0} !== {1'b1, 32'h108, 1'b0, 32'h105}) begin
      fails++; $display("FAIL blx_branch: got %h exp %h", {br0, tgt0, th0, lwd0}, {1'b1, 32'h108, 1'b0, 32'h105});
    end
    drive(1, 0, 0, 16'hF000, 32'h100, 32'h0); step();
    drive(1, 0, 0, 16'hE803, 32'h102, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL blx_odd u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({ud0, br0, lwe0} !== 3'b100) begin fails++; $display("FAIL blx_odd_undef: got %b exp 100", {ud0, br0, lwe0}); end
  endtask

  task automatic test_flush_stall();
    drive(1, 0, 0, 16'hF000, 32'h0, 32'h0); step();
    drive(1, 0, 1, 16'hF801, 32'h2, 32'h0); step();
    tests++;
    if ({br0, pend0, lwe0, br1, pend1} !== 5'b0) begin
      fails++; $display("FAIL flush: got %b exp 00000", {br0, pend0, lwe0, br1, pend1});
    end
    drive(1, 0, 0, 16'hF000, 32'h0, 32'h0); step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 16'hF801, 32'h2, 32'h0); step();
      tests++;
      if ({br0, pend0} !== 2'b01) begin fails++; $display("FAIL stall_hold c%0d: got %b exp 01", c, {br0, pend0}); end
    end
    drive(1, 0, 0, 16'hF801, 32'h2, 32'h0); step();
    tests++;
    if ({br0, tgt0, pend0} !== {1'b1, 32'h6, 1'b0}) begin
      fails++; $display("FAIL stall_release: got %h exp %h", {br0, tgt0, pend0}, {1'b1, 32'h6, 1'b0});
    end
    drive(0, 0, 0, 16'h0, 32'h0, 32'h0); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL stall_after u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
  endtask

  task automatic test_orphan();
    drive(1, 0, 0, 16'h0000, 32'h10, 32'h0); step();
    drive(1, 0, 0, 16'hF801, 32'h20, 32'h400); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL orphan u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({br0, tgt0, lwd0, ud0} !== {1'b1, 32'h402, 32'h23, 1'b0}) begin
      fails++; $display("FAIL orphan_allowed: got %h exp %h", {br0, tgt0, lwd0, ud0}, {1'b1, 32'h402, 32'h23, 1'b0});
    end
    tests++;
    if ({ud1, br1, lwe1} !== 3'b100) begin fails++; $display("FAIL orphan_undef: got %b exp 100", {ud1, br1, lwe1}); end
  endtask

  task automatic test_reset_midpair();
    drive(1, 0, 0, 16'hF123, 32'h80, 32'h0); step();
    tests++;
    if (pend0 !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b exp 1", pend0); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL mid_reset u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1, 0, 0, 16'hF801, 32'h20, 32'h400); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin fails++; $display("FAIL mid_orphan u%0d: got %h exp %h", k, obs(k), expv(k)); end
    end
    tests++;
    if ({br0, tgt0} !== {1'b1, 32'h402}) begin fails++; $display("FAIL mid_orphan_tgt: got %h exp %h", {br0, tgt0}, {1'b1, 32'h402}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      int unsigned r;
      logic [15:0] ins;
      r = $urandom_range(0, 9);
      ins = 16'($urandom);
      if (r < 3)      ins[15:11] = 5'b11110;
      else if (r < 6) ins[15:11] = 5'b11111;
      else if (r < 8) ins[15:11] = 5'b11101;
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
            ins, $urandom, $urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin fails++; $display("FAIL random n%0d u%0d: got %h exp %h", n, k, obs(k), expv(k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bl_basic();
    test_neg_wrap();
    test_blx();
    test_flush_stall();
    test_orphan();
    test_reset_midpair();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
